dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Initiator-side controller that drives the 8-bit data memory port: address, in_data, out_data, w_en and en.
- Accepts single or burst load/store requests from the CPU datapath and sequences the memory enables with a programmable address-setup time.
- Returns read data with a valid pulse.
- Sits between the load/store stage and data memory; it is the only master of the memory port.

Parameters:
AW, 8, address width (mem_addr, req_addr)
DW, 8, data width
WAIT_CYC, 1, setup cycles the address and en are held before the strobe/sample; legal range 1..15

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  request; sampled only in IDLE
req_we  in  1  1 = store burst, 0 = load burst
req_addr  in  AW  start address
req_len  in  4  number of beats minus 1 (0 = single, 15 = 16 beats)
req_ack  out  1  1-cycle pulse: request accepted
wdata  in  DW  store data for the current beat
wdata_valid  in  1  wdata present
wdata_ready  out  1  controller can take wdata this cycle
rdata  out  DW  load data
rdata_valid  out  1  1-cycle pulse per load beat
busy  out  1  high from acceptance until the last strobe completes
done  out  1  1-cycle pulse after the final beat
mem_addr  out  AW  to memory address
mem_in_data  out  DW  to memory in_data
mem_out_data  in  DW  from memory out_data
mem_en  out  1  memory enable
mem_w_en  out  1  memory write enable

Behaviour:
- All outputs are registered. On rst, asynchronously and immediately: state=IDLE, every output 0 (mem_addr=0, mem_in_data=0, rdata=0).
- States: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - busy=0, mem_en=0, mem_w_en=0, wdata_ready=0.
  - req=1 at an edge latches req_we, req_addr and req_len into cur_addr, beats and we.
  - It also loads wait_cnt=WAIT_CYC and moves to SETUP.
  - req_ack=1 and busy=1 in the following cycle.
- SETUP:
  - mem_en=1, mem_addr=cur_addr, mem_w_en=0.
  - wait_cnt decrements once per cycle.
  - Store only: wdata_ready=1 until a beat is captured. On wdata_valid&wdata_ready, mem_in_data<=wdata and wdata_ready drops next cycle.
  - Exit to STROBE when wait_cnt reaches 0 AND (load, or store data captured).
  - A store stalls in SETUP indefinitely without wdata_valid; mem_en stays 1 during the stall.
- STROBE (exactly 1 cycle):
  - mem_en=1, and mem_addr and mem_in_data are held.
  - Store: mem_w_en=1 for this cycle only.
  - Load: rdata<=mem_out_data at the closing edge, and rdata_valid=1 in the next cycle.
  - If beats==0, go to DONE. Otherwise cur_addr<=cur_addr+1 (mod 2^AW, so 0xFF wraps to 0x00), beats<=beats-1, wait_cnt<=WAIT_CYC, and go to SETUP.
- DONE (1 cycle):
  - done=1, busy=0, mem_en=0.
  - req is ignored in DONE; next state is IDLE.
- Invariants:
  - mem_addr never changes in a cycle where mem_w_en=1.
  - mem_w_en=1 implies mem_en=1.
  - mem_w_en never rises in SETUP.
- Beat latency is WAIT_CYC+1 cycles, excluding store stalls.
- Single load with WAIT_CYC=1, req sampled at edge E0:
  - SETUP in cycle 1, STROBE in cycle 2.
  - rdata_valid=1 and done=1 together in cycle 3.
  - busy=1 in cycles 1-2.
- req while busy or in DONE is ignored: no ack, and latched fields are unchanged.
- req_len, req_addr and req_we changes after acceptance have no effect.
- Reset mid-burst: the burst is abandoned with no done pulse and mem_w_en drops asynchronously. Beats already strobed remain written in memory.
- wdata_valid outside SETUP of a store is ignored.

Test Plan:
- Store addr=0x09, data=45, len=0, WAIT_CYC=1, wdata_valid held high -> req_ack next cycle; mem_w_en high exactly 1 cycle with mem_addr=0x09 and mem_in_data=45; done 1 cycle later; memory[0x09]=45.
- Load 0x09 after the previous store -> rdata=45, rdata_valid and done both high in cycle 3 after the req edge; mem_w_en stays 0 throughout.
- Store burst addr=0xFE, len=3, data 1,2,3,4 -> writes to 0xFE,0xFF,0x00,0x01; four mem_w_en pulses spaced 2 cycles apart; one done pulse; a load burst reads back 1,2,3,4 with four rdata_valid pulses.
- Store with wdata_valid withheld 5 cycles -> controller stays in SETUP with mem_en=1 and mem_w_en=0; it strobes 1 cycle after wdata_valid rises; the written value equals wdata at capture.
- WAIT_CYC=3 load burst len=1 -> each beat takes 4 cycles; a req pulsed while busy gets no req_ack and does not alter the burst.
- Assert rst during the 2nd beat of a 4-beat store -> all outputs 0 immediately and no done pulse; only beat 0 is written in memory; a new req after reset is acked normally.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bundles the CPU request/response handshake and the data-memory port of the
// access controller; master is the controller view, slave the CPU+memory view.
interface dmem_access_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic          req_ack;
  logic [DW-1:0] wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in_data;
  logic [DW-1:0] mem_out_data;
  logic          mem_en;
  logic          mem_w_en;

  modport master (
    input  req, req_we, req_addr, req_len, wdata, wdata_valid, mem_out_data,
    output req_ack, wdata_ready, rdata, rdata_valid, busy, done,
           mem_addr, mem_in_data, mem_en, mem_w_en
  );

  modport slave (
    output req, req_we, req_addr, req_len, wdata, wdata_valid, mem_out_data,
    input  req_ack, wdata_ready, rdata, rdata_valid, busy, done,
           mem_addr, mem_in_data, mem_en, mem_w_en
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Burst load/store sequencer for an 8-bit data memory port: holds address and
// enable for WAIT_CYC setup cycles, then strobes write or samples read data.
module dmem_access_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input logic               clk,
  input logic               rst,
  dmem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYC);
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]    beats_q, beats_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          we_q, we_d;
  logic          captured_q, captured_d;
  logic          req_ack_q, req_ack_d;
  logic          wdata_ready_q, wdata_ready_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] mem_in_data_q, mem_in_data_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_w_en_q, mem_w_en_d;

  logic wait_expired;
  logic capture;

  // A count of 1 means this is the last setup cycle; 0 only occurs while a store stalls.
  assign wait_expired = (wait_cnt_q <= 4'd1);
  assign capture      = (state_q == SETUP) && wdata_ready_q && bus.wdata_valid;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    beats_d       = beats_q;
    wait_cnt_d    = wait_cnt_q;
    we_d          = we_q;
    captured_d    = captured_q;
    req_ack_d     = 1'b0;
    wdata_ready_d = wdata_ready_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    mem_in_data_d = mem_in_data_q;
    mem_en_d      = mem_en_q;
    mem_w_en_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cur_addr_d    = bus.req_addr;
          beats_d       = bus.req_len;
          we_d          = bus.req_we;
          wait_cnt_d    = WAIT_INIT;
          captured_d    = 1'b0;
          req_ack_d     = 1'b1;
          busy_d        = 1'b1;
          mem_en_d      = 1'b1;
          wdata_ready_d = bus.req_we;
          state_d       = SETUP;
        end
      end

      SETUP: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
        if (capture) begin
          mem_in_data_d = bus.wdata;
          wdata_ready_d = 1'b0;
          captured_d    = 1'b1;
        end
        // Data captured on this same edge is good enough to strobe next cycle.
        if (wait_expired && (!we_q || captured_q || capture)) begin
          state_d       = STROBE;
          mem_w_en_d    = we_q;
          wdata_ready_d = 1'b0;
        end
      end

      STROBE: begin
        if (!we_q) begin
          rdata_d       = bus.mem_out_data;
          rdata_valid_d = 1'b1;
        end
        if (beats_q == 4'd0) begin
          state_d  = DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          mem_en_d = 1'b0;
        end else begin
          cur_addr_d    = cur_addr_q + ADDR_ONE;
          beats_d       = beats_q - 4'd1;
          wait_cnt_d    = WAIT_INIT;
          captured_d    = 1'b0;
          wdata_ready_d = we_q;
          state_d       = SETUP;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      beats_q       <= '0;
      wait_cnt_q    <= '0;
      we_q          <= 1'b0;
      captured_q    <= 1'b0;
      req_ack_q     <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_in_data_q <= '0;
      mem_en_q      <= 1'b0;
      mem_w_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      beats_q       <= beats_d;
      wait_cnt_q    <= wait_cnt_d;
      we_q          <= we_d;
      captured_q    <= captured_d;
      req_ack_q     <= req_ack_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_in_data_q <= mem_in_data_d;
      mem_en_q      <= mem_en_d;
      mem_w_en_q    <= mem_w_en_d;
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_addr    = cur_addr_q;
  assign bus.mem_in_data = mem_in_data_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_w_en    = mem_w_en_q;

endmodule
